// File: rtl/crc5_4bit_parallel_usb2.sv
// crc5_4bit_parallel_usb2: USB CRC-5 (x^5+x^2+1), 4 bits per clock with data_in[0] first in time.
// Define CRC5_OUT_INVERT_EN to drive CRC as the ones-complement of the state.
module crc5_4bit_parallel_usb2 #(
  parameter logic [4:0] RESET_SEED = 5'h1F
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic [3:0] data_in,
  input  logic       enable,
  input  logic       clear,
  output logic [4:0] CRC
);
  logic [4:0] crc_q, crc_d, upd;
  // Four serial LFSR steps unrolled into one XOR layer
  always_comb begin
    upd[0] = crc_q[1] ^ crc_q[4] ^ data_in[0] ^ data_in[3];
    upd[1] = crc_q[2] ^ data_in[2];
    upd[2] = crc_q[1] ^ crc_q[3] ^ crc_q[4] ^ data_in[0] ^ data_in[1] ^ data_in[3];
    upd[3] = crc_q[2] ^ crc_q[4] ^ data_in[0] ^ data_in[2];
    upd[4] = crc_q[0] ^ crc_q[3] ^ data_in[1];
  end
  always_comb crc_d = clear ? RESET_SEED : enable ? upd : crc_q;
  always_ff @(posedge CLK)
    if (!RSTn) crc_q <= RESET_SEED;
    else crc_q <= crc_d;
`ifdef CRC5_OUT_INVERT_EN
  assign CRC = ~crc_q;
`else
  assign CRC = crc_q;
`endif
endmodule

// File: tb/tb_crc5_4bit_parallel_usb2.sv
// tb_crc5_4bit_parallel_usb2: directed and random checks of two CRC-5 instances seeded 5'h00 and 5'h1F.
module tb_crc5_4bit_parallel_usb2;
  logic       CLK = 1'b0;
  logic       RSTn;
  logic [3:0] data_in;
  logic       enable, clear;
  logic [4:0] crc0, crc1;
  int vectors = 0, miscompares = 0;

  always #5 CLK = ~CLK;

  crc5_4bit_parallel_usb2 #(.RESET_SEED(5'h00)) u0 (
    .CLK(CLK), .RSTn(RSTn), .data_in(data_in), .enable(enable), .clear(clear), .CRC(crc0)
  );
  crc5_4bit_parallel_usb2 #(.RESET_SEED(5'h1F)) u1 (
    .CLK(CLK), .RSTn(RSTn), .data_in(data_in), .enable(enable), .clear(clear), .CRC(crc1)
  );

  function automatic logic [4:0] out_of(input logic [4:0] v);
`ifdef CRC5_OUT_INVERT_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  function automatic logic [4:0] serial_model(input logic [4:0] c, input logic [3:0] d);
    logic [4:0] s;
    logic fb;
    s = c;
    for (int i = 0; i < 4; i++) begin
      fb = s[4] ^ d[i];
      s = {s[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
    end
    return s;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1; enable = 1'b0;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    RSTn = 1'b0; data_in = 'x; enable = 'x; clear = 'x;
    repeat (3) tick();
    vectors++;
    if (crc0 !== out_of(5'h00)) begin
      miscompares++;
      $display("FAIL reset_seed00: got %h want %h", crc0, out_of(5'h00));
    end
    vectors++;
    if (crc1 !== out_of(5'h1F)) begin
      miscompares++;
      $display("FAIL reset_seed1F: got %h want %h", crc1, out_of(5'h1F));
    end
    RSTn = 1'b1; enable = 1'b0; clear = 1'b0; data_in = 4'h0;
  endtask

  task automatic test_single();
    do_clear();
    enable = 1'b1; data_in = 4'h1;
    tick();
    enable = 1'b0;
    vectors++;
    if (crc0 !== out_of(5'h0D)) begin
      miscompares++;
      $display("FAIL single_00_n1: got %h want %h", crc0, out_of(5'h0D));
    end
    do_clear();
    enable = 1'b1; data_in = 4'h0;
    tick();
    enable = 1'b0;
    vectors++;
    if (crc1 !== out_of(5'h06)) begin
      miscompares++;
      $display("FAIL single_1F_n0: got %h want %h", crc1, out_of(5'h06));
    end
  endtask

  task automatic test_stream();
    logic [4:0] e0 [2] = '{5'h0D, 5'h0E};
    logic [4:0] e1 [2] = '{5'h0B, 5'h01};
    logic [3:0] nib [2] = '{4'h1, 4'h0};
    do_clear();
    enable = 1'b1;
    for (int i = 0; i < 2; i++) begin
      data_in = nib[i];
      tick();
      vectors++;
      if (crc0 !== out_of(e0[i]) || crc1 !== out_of(e1[i])) begin
        miscompares++;
        $display("FAIL stream[%0d]: got %h/%h want %h/%h", i, crc0, crc1, out_of(e0[i]), out_of(e1[i]));
      end
    end
    enable = 1'b0;
    do_clear();
    enable = 1'b1; data_in = 4'h0;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (crc0 !== out_of(5'h00)) begin
        miscompares++;
        $display("FAIL zero_stream[%0d]: got %h want %h", i, crc0, out_of(5'h00));
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_hold();
    do_clear();
    enable = 1'b1; data_in = 4'h1;
    tick();
    data_in = 4'h0;
    tick();
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      data_in = 4'($urandom);
      tick();
      vectors++;
      if (crc0 !== out_of(5'h0E)) begin
        miscompares++;
        $display("FAIL hold[%0d]: got %h want %h", i, crc0, out_of(5'h0E));
      end
    end
  endtask

  task automatic test_clear_priority();
    clear = 1'b1; enable = 1'b1; data_in = 4'h1;
    tick();
    vectors++;
    if (crc0 !== out_of(5'h00) || crc1 !== out_of(5'h1F)) begin
      miscompares++;
      $display("FAIL clear_with_enable: got %h/%h want %h/%h", crc0, crc1, out_of(5'h00), out_of(5'h1F));
    end
    clear = 1'b0; data_in = 4'h1;
    tick();
    clear = 1'b1; enable = 1'b0;
    tick();
    clear = 1'b0;
    vectors++;
    if (crc0 !== out_of(5'h00) || crc1 !== out_of(5'h1F)) begin
      miscompares++;
      $display("FAIL clear_only: got %h/%h want %h/%h", crc0, crc1, out_of(5'h00), out_of(5'h1F));
    end
  endtask

  task automatic test_reset_midstream();
    enable = 1'b1; data_in = 4'h9;
    tick();
    RSTn = 1'b0; data_in = 4'h5;
    tick();
    RSTn = 1'b1; enable = 1'b0;
    vectors++;
    if (crc0 !== out_of(5'h00) || crc1 !== out_of(5'h1F)) begin
      miscompares++;
      $display("FAIL reset_midstream: got %h/%h want %h/%h", crc0, crc1, out_of(5'h00), out_of(5'h1F));
    end
  endtask

  task automatic test_random();
    logic [4:0] m0, m1;
    m0 = 5'h00; m1 = 5'h1F;
    do_clear();
    for (int i = 0; i < 1000; i++) begin
      RSTn = ($urandom_range(0, 49) != 0);
      clear = ($urandom_range(0, 15) == 0);
      enable = ($urandom_range(0, 3) != 0);
      data_in = 4'($urandom);
      if (!RSTn || clear) begin
        m0 = 5'h00; m1 = 5'h1F;
      end else if (enable) begin
        m0 = serial_model(m0, data_in);
        m1 = serial_model(m1, data_in);
      end
      tick();
      vectors++;
      if (crc0 !== out_of(m0) || crc1 !== out_of(m1)) begin
        miscompares++;
        $display("FAIL random[%0d]: got %h/%h want %h/%h", i, crc0, crc1, out_of(m0), out_of(m1));
      end
    end
    RSTn = 1'b1; clear = 1'b0; enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_hold();
    test_clear_priority();
    test_reset_midstream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
